// File: rtl/regfile_param_if.sv
// ---------------------------------------------------------------------------
// regfile_param_if
// Bundles the register file's write, reservation and read signals so the
// decode/writeback side (master) and the register file (slave) can be wired
// with a single port.
//
// Parameters: DATA_WIDTH (bits per register), ADDR_WIDTH (index width),
//             NUM_READ (number of read ports).
// Signals:
//   ctrl_writeEn / ctrl_writeReg / data_writeReg : writeback strobe, index, data
//   ctrl_reserveEn / ctrl_reserveReg             : mark a register busy at issue
//   ctrl_readReg   : packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   data_readReg   : packed read data,    port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy_readReg   : busy bit of each read port's register
//   busy_any       : OR of busy_readReg
// ---------------------------------------------------------------------------
interface regfile_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic                           ctrl_writeEn;
    logic [ADDR_WIDTH-1:0]          ctrl_writeReg;
    logic [DATA_WIDTH-1:0]          data_writeReg;
    logic                           ctrl_reserveEn;
    logic [ADDR_WIDTH-1:0]          ctrl_reserveReg;
    logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg;
    logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
    logic [NUM_READ-1:0]            busy_readReg;
    logic                           busy_any;

    // Pipeline side: drives requests, observes read results.
    modport master (
        output ctrl_writeEn, ctrl_writeReg, data_writeReg,
        output ctrl_reserveEn, ctrl_reserveReg, ctrl_readReg,
        input  data_readReg, busy_readReg, busy_any
    );

    // Register file side.
    modport slave (
        input  ctrl_writeEn, ctrl_writeReg, data_writeReg,
        input  ctrl_reserveEn, ctrl_reserveReg, ctrl_readReg,
        output data_readReg, busy_readReg, busy_any
    );
endinterface

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
// Parametrised multi-read / single-write register file with a per-register
// busy scoreboard used by the hazard logic to stall on pending writebacks.
// Register 0 is hardwired to zero and can never be marked busy.
//
// Ports:
//   clock      : system clock, all state changes on posedge
//   ctrl_reset : synchronous active-high reset, clears data and busy bits
//   bus        : regfile_param_if.slave (write, reserve and read signals)
//
// Optional build macro: REGFILE_BYPASS_EN
//   Defined   -> a write in flight is forwarded combinationally to any read
//                port addressing the same (non-zero) index.
//   Undefined -> reads show the stored value until the write commits.
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input logic            clock,
    input logic            ctrl_reset,
    regfile_param_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (NUM_READ < 1 || NUM_READ > 4) begin : g_badNumRead
            $error("regfile_param: NUM_READ must be in 1..4");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_busy;

    logic [ADDR_WIDTH-1:0] w_readIdx  [NUM_READ];
    logic [DATA_WIDTH-1:0] w_readData [NUM_READ];
    logic [NUM_READ-1:0]   w_readBusy;

    // Storage and scoreboard update. The reserve assignment comes after the
    // write's busy clear so that a same-index write+reserve leaves the
    // register busy: the newer producer is still outstanding.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (bus.ctrl_writeEn && (bus.ctrl_writeReg != '0)) begin
                r_regs[bus.ctrl_writeReg] <= bus.data_writeReg;
                r_busy[bus.ctrl_writeReg] <= 1'b0;
            end
            if (bus.ctrl_reserveEn && (bus.ctrl_reserveReg != '0)) begin
                r_busy[bus.ctrl_reserveReg] <= 1'b1;
            end
        end
    end

    // Zero-latency read ports. Index 0 is forced to zero data / not busy
    // regardless of array contents.
    always_comb begin
        w_readBusy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            w_readIdx[p]  = bus.ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];
            w_readData[p] = (w_readIdx[p] == '0) ? '0 : r_regs[w_readIdx[p]];
            w_readBusy[p] = (w_readIdx[p] == '0) ? 1'b0 : r_busy[w_readIdx[p]];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; busy is clear unless the same
            // register is being re-reserved in this very cycle.
            if (bus.ctrl_writeEn && (bus.ctrl_writeReg != '0) &&
                (w_readIdx[p] == bus.ctrl_writeReg)) begin
                w_readData[p] = bus.data_writeReg;
                w_readBusy[p] = bus.ctrl_reserveEn &&
                                (bus.ctrl_reserveReg == w_readIdx[p]);
            end
`endif
        end
    end

    // Pack per-port results onto the flat output buses.
    always_comb begin
        bus.data_readReg = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            bus.data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = w_readData[p];
        end
    end

    assign bus.busy_readReg = w_readBusy;
    assign bus.busy_any     = |w_readBusy;

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
// Self-checking bench for regfile_param. A 2-read-port instance carries the
// main vector table; a 4-read-port instance shares its write/reserve inputs
// and is used for the wide-port reads.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    typedef struct {
        logic        rst;
        logic        wEn;
        logic [4:0]  wReg;
        logic [31:0] wData;
        logic        rEn;
        logic [4:0]  rReg;
        logic [4:0]  readA;
        logic [4:0]  readB;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [1:0]  expBusy;
    } vec_t;

    typedef struct {
        logic [31:0] expA;
        logic [31:0] expB;
        logic [1:0]  expBusy;
    } expect_t;

    logic    clock = 1'b0;
    logic    ctrl_reset;
    int      checks   = 0;
    int      failures = 0;
    expect_t sbQueue[$];
    vec_t    vecs[16];

    // Free-running clock, 10 time-unit period.
    always #5 clock = ~clock;

    regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus ();
    regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) bus4 ();

    // The wide instance mirrors every write/reserve of the main instance.
    assign bus4.ctrl_writeEn    = bus.ctrl_writeEn;
    assign bus4.ctrl_writeReg   = bus.ctrl_writeReg;
    assign bus4.data_writeReg   = bus.data_writeReg;
    assign bus4.ctrl_reserveEn  = bus.ctrl_reserveEn;
    assign bus4.ctrl_reserveReg = bus.ctrl_reserveReg;

    regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) u_dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) u_dut4 (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus4)
    );

    // Queue the expected read results for the current read addresses.
    task automatic pushExpect(input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] busy);
        expect_t e;
        e.expA    = a;
        e.expB    = b;
        e.expBusy = busy;
        sbQueue.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the 2-port DUT outputs.
    task automatic checkOutput(input string name);
        expect_t e;
        checks++;
        if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, nothing to compare", name);
        end else begin
            e = sbQueue.pop_front();
            if (bus.data_readReg[31:0] !== e.expA ||
                bus.data_readReg[63:32] !== e.expB ||
                bus.busy_readReg !== e.expBusy ||
                bus.busy_any !== (|e.expBusy)) begin
                failures++;
                $display("[TB] FAIL %s: got A=%0d(0x%h) B=%0d(0x%h) busy=%b any=%b, expected A=%0d(0x%h) B=%0d(0x%h) busy=%b any=%b",
                         name, $signed(bus.data_readReg[31:0]), bus.data_readReg[31:0],
                         $signed(bus.data_readReg[63:32]), bus.data_readReg[63:32],
                         bus.busy_readReg, bus.busy_any,
                         $signed(e.expA), e.expA, $signed(e.expB), e.expB,
                         e.expBusy, |e.expBusy);
            end
        end
    endtask

    // Compare one port of the 4-port instance.
    task automatic check4(input string name, input int port,
                          input logic [31:0] exp, input logic expBusy);
        logic [31:0] got;
        got = bus4.data_readReg[port*32 +: 32];
        checks++;
        if (got !== exp || bus4.busy_readReg[port] !== expBusy) begin
            failures++;
            $display("[TB] FAIL %s port%0d: got 0x%h busy=%b, expected 0x%h busy=%b",
                     name, port, got, bus4.busy_readReg[port], exp, expBusy);
        end
    endtask

    // One table row: set reads, check state left by earlier rows, then
    // present this row's controls for the coming posedge.
    task automatic applyStimulus(input vec_t v, input int row);
        @(negedge clock);
        ctrl_reset         = 1'b0;
        bus.ctrl_writeEn   = 1'b0;
        bus.ctrl_reserveEn = 1'b0;
        bus.ctrl_readReg   = {v.readB, v.readA};
        pushExpect(v.expA, v.expB, v.expBusy);
        #1;
        checkOutput($sformatf("vec%0d", row));
        ctrl_reset          = v.rst;
        bus.ctrl_writeEn    = v.wEn;
        bus.ctrl_writeReg   = v.wReg;
        bus.data_writeReg   = v.wData;
        bus.ctrl_reserveEn  = v.rEn;
        bus.ctrl_reserveReg = v.rReg;
    endtask

    initial begin
        logic [31:0] expSame;

        // Row fields: rst wEn wReg wData rEn rReg readA readB expA expB expBusy
        vecs[0]  = '{0, 1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        vecs[1]  = '{1, 1, 5'd3,  32'h11111111, 0, 5'd0,  5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
        vecs[2]  = '{0, 1, 5'd0,  32'h12345678, 0, 5'd0,  5'd3,  5'd3,  32'h0,        32'h0,        2'b00};
        vecs[3]  = '{0, 0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        vecs[4]  = '{0, 1, 5'd5,  32'hFFFFFFF9, 0, 5'd0,  5'd0,  5'd3,  32'h0,        32'h0,        2'b00};
        vecs[5]  = '{0, 1, 5'd31, 32'h7FFFFFFF, 0, 5'd0,  5'd5,  5'd0,  32'hFFFFFFF9, 32'h0,        2'b00};
        vecs[6]  = '{0, 0, 5'd0,  32'h0,        1, 5'd9,  5'd5,  5'd31, 32'hFFFFFFF9, 32'h7FFFFFFF, 2'b00};
        vecs[7]  = '{0, 1, 5'd9,  32'd42,       0, 5'd0,  5'd9,  5'd5,  32'h0,        32'hFFFFFFF9, 2'b01};
        vecs[8]  = '{0, 1, 5'd9,  32'd42,       1, 5'd9,  5'd5,  5'd9,  32'hFFFFFFF9, 32'd42,       2'b00};
        vecs[9]  = '{0, 1, 5'd9,  32'd43,       1, 5'd7,  5'd9,  5'd9,  32'd42,       32'd42,       2'b11};
        vecs[10] = '{0, 1, 5'd7,  32'd77,       0, 5'd0,  5'd9,  5'd7,  32'd43,       32'h0,        2'b10};
        vecs[11] = '{1, 0, 5'd0,  32'h0,        1, 5'd20, 5'd7,  5'd9,  32'd77,       32'd43,       2'b00};
        vecs[12] = '{0, 1, 5'd31, 32'hA5A5A5A5, 0, 5'd0,  5'd20, 5'd9,  32'h0,        32'h0,        2'b00};
        vecs[13] = '{0, 0, 5'd0,  32'h0,        1, 5'd31, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
        vecs[14] = '{0, 1, 5'd31, 32'h0BADF00D, 0, 5'd0,  5'd31, 5'd0,  32'hA5A5A5A5, 32'h0,        2'b01};
        vecs[15] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd31, 32'h0,        32'h0BADF00D, 2'b00};

        ctrl_reset          = 1'b1;
        bus.ctrl_writeEn    = 1'b0;
        bus.ctrl_writeReg   = '0;
        bus.data_writeReg   = '0;
        bus.ctrl_reserveEn  = 1'b0;
        bus.ctrl_reserveReg = '0;
        bus.ctrl_readReg    = '0;
        bus4.ctrl_readReg   = '0;
        repeat (2) @(posedge clock);

        // Every index on every port reads zero and not busy after reset.
        @(negedge clock);
        ctrl_reset = 1'b0;
        for (int idx = 0; idx < 32; idx++) begin
            @(negedge clock);
            bus.ctrl_readReg  = {2{idx[4:0]}};
            bus4.ctrl_readReg = {4{idx[4:0]}};
            pushExpect(32'h0, 32'h0, 2'b00);
            #1;
            checkOutput($sformatf("resetRead%0d", idx));
            for (int p = 0; p < 4; p++) begin
                check4($sformatf("resetRead4_%0d", idx), p, 32'h0, 1'b0);
            end
        end

        // Same-cycle write while reading: stored value 7, new value 100.
        @(negedge clock);
        bus.ctrl_writeEn  = 1'b1;
        bus.ctrl_writeReg = 5'd12;
        bus.data_writeReg = 32'd7;
        @(negedge clock);
        bus.ctrl_readReg  = {5'd12, 5'd12};
        bus.data_writeReg = 32'd100;
`ifdef REGFILE_BYPASS_EN
        expSame = 32'd100;
`else
        expSame = 32'd7;
`endif
        pushExpect(expSame, expSame, 2'b00);
        #1;
        checkOutput("sameCycleBefore");
        @(negedge clock);
        bus.ctrl_writeEn = 1'b0;
        pushExpect(32'd100, 32'd100, 2'b00);
        #1;
        checkOutput("sameCycleAfter");

        // All four ports of the wide instance on the same register.
        bus.ctrl_writeEn  = 1'b1;
        bus.ctrl_writeReg = 5'd31;
        bus.data_writeReg = 32'h7FFFFFFF;
        @(negedge clock);
        bus.ctrl_writeEn  = 1'b0;
        bus4.ctrl_readReg = {4{5'd31}};
        #1;
        for (int p = 0; p < 4; p++) begin
            check4("allPorts31", p, 32'h7FFFFFFF, 1'b0);
        end

        // Clean reset, then the vector table.
        @(negedge clock);
        ctrl_reset = 1'b1;
        for (int row = 0; row < 16; row++) begin
            applyStimulus(vecs[row], row);
        end
        @(negedge clock);
        ctrl_reset         = 1'b0;
        bus.ctrl_writeEn   = 1'b0;
        bus.ctrl_reserveEn = 1'b0;

        if (sbQueue.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sbQueue.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the processor's 2-read/1-write register file.
- Generalised in data width, depth and read-port count.
- Adds a per-register busy scoreboard that the pipeline's hazard logic uses to stall on pending writebacks.
- Sits between decode (reads, reservations) and writeback (writes) in the pipelined core.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of independent read ports; legal range 1..4.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- ctrl_reset  input  1  synchronous active-high reset.
- ctrl_writeEn  input  1  write strobe.
- ctrl_writeReg  input  ADDR_WIDTH  write index.
- data_writeReg  input  DATA_WIDTH  write data.
- ctrl_reserveEn  input  1  mark ctrl_reserveReg busy (issue of a producing instruction).
- ctrl_reserveReg  input  ADDR_WIDTH  index to reserve.
- ctrl_readReg  input  NUM_READ*ADDR_WIDTH  read indices; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- data_readReg  output  NUM_READ*DATA_WIDTH  read data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- busy_readReg  output  NUM_READ  busy bit of each read port's register.
- busy_any  output  1  OR of busy_readReg.

Behaviour:
- One clock (clock); reset ctrl_reset is synchronous and active-high. Asserted at a posedge, it clears every register to 0 and every busy bit to 0.
- Reset priority: in the reset cycle, write and reserve are ignored.
- Outputs after reset: data_readReg all 0, busy_readReg 0, busy_any 0.
- Register 0:
  - Reads as 0 always.
  - Writes to index 0 are discarded.
  - Reservations of index 0 are discarded; busy bit 0 reads 0.
- Write: on posedge with ctrl_writeEn=1 and index != 0, reg[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0.
- Reserve: on posedge with ctrl_reserveEn=1 and index != 0, busy[ctrl_reserveReg] <= 1.
- Simultaneous write and reserve, same index: data is written and busy ends at 1, i.e. the newer producer wins.
- Simultaneous write and reserve, different indices: both take effect independently.
- Reads: combinational (zero-latency) from the register array, all NUM_READ ports independent. Any port may address any index, including several ports on the same index.
- busy_readReg[i] is combinational from the busy array (no bypass), so a write in cycle N clears busy visibly only after posedge N.
- Reset asserted mid-operation (busy bits set, writes in flight) discards all pending state; no write completes that cycle.
- Out-of-range NUM_READ is rejected at elaboration (generate-time error).
- Width rule: data is stored and returned unmodified. No sign handling; the bench compares with $signed for display only.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If ctrl_writeEn=1, ctrl_writeReg != 0 and ctrl_readReg port i == ctrl_writeReg, then data_readReg port i = data_writeReg combinationally in the same cycle, and busy_readReg[i] = 0 unless a same-index reserve is also active that cycle.
- Not defined: reads return the stored value until the posedge commits the write; busy behaviour is exactly as in Behaviour.

Test Plan:
- Reset then read all 32 indices on every port -> all data 0, busy 0. Write reg3=0xDEADBEEF, then assert reset together with another write to reg3 -> reg3 reads 0 next cycle.
- Write reg0=0x12345678, then read reg0 on all ports -> 0. Reserve reg0 -> busy stays 0.
- Write reg5=-7 and reg31=0x7FFFFFFF on consecutive cycles. Read A=5, B=31 at the following negedge -> -7 and 2147483647. With NUM_READ=4 and all ports set to 31 -> all ports 0x7FFFFFFF.
- Reserve reg9 -> busy_readReg for port reading 9 = 1 and busy_any=1 after the posedge. Write reg9=42 -> busy clears after the posedge and data reads 42. Write and reserve reg9 in the same cycle -> data 42, busy 1.
- Same-cycle write reg12=100 while reading 12 (old value 7):
  - REGFILE_BYPASS_EN defined -> reads 100 before the posedge.
  - Not defined -> reads 7 before the posedge, 100 after.
- Run the existing regfile CSV vectors (writeEn, reset, writeReg, writeData, readA, readB, expA, expB) with default parameters and bypass off -> zero errors, checked at the negedge sample point.
